// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch/lap timer: state codes,
// seconds limits and the preset clamp helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam int SEC_W = 6;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

  function automatic logic [SEC_W-1:0] clamp_sec(
    input logic [SEC_W-1:0] s
  );
    return (s > SEC_MAX) ? SEC_MAX : s;
  endfunction

endpackage

// File: rtl/lap_fifo.sv
// Small synchronous FIFO holding captured lap times; head is shown
// directly from storage so all outputs come from flops.
module lap_fifo #(
  parameter int DW    = 14,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] head,
  output logic          valid,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  always_comb begin
    cnt     = wr_q - rd_q;
    valid   = (cnt != '0);
    full    = (cnt == FULL_CNT);
    head    = mem_q[rd_q[AW-1:0]];
    do_pop  = pop & valid;
    // a pop in the same cycle frees the slot the push needs
    do_push = push & (~full | do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (clr) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q[AW-1:0]] = din;
        wr_d = wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_d = rd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

endmodule

// File: rtl/stopwatch_lap_timer.sv
// Minutes:seconds stopwatch with up/down count, countdown alarm
// and a lap-capture FIFO drained by the host.
module stopwatch_lap_timer
  import stopwatch_pkg::*;
#(
  parameter int MIN_W     = 8,
  parameter int TICK_DIV  = 1,
  parameter int LAP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             reset,
  input  logic             mode,
  input  logic [MIN_W-1:0] load_min,
  input  logic [SEC_W-1:0] load_sec,
  input  logic             lap,
  input  logic             lap_pop,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic [1:0]       status,
  output logic             alarm,
  output logic             ovf,
  output logic             lap_valid,
  output logic [MIN_W-1:0] lap_min,
  output logic [SEC_W-1:0] lap_sec,
  output logic             lap_full
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [MIN_W-1:0] MIN_MAX = '1;

  typedef struct packed {
    logic [MIN_W-1:0] m;
    logic [SEC_W-1:0] s;
  } lap_t;

  state_e           state_q, state_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             mode_q, mode_d;
  logic             alarm_q, alarm_d;
  logic             ovf_q, ovf_d;
  logic             tick;
  logic             fifo_clr;
  logic             lap_push;
  logic [SEC_W-1:0] preset_sec;
  lap_t             lap_in, lap_head;

  always_comb begin
    state_d    = state_q;
    min_d      = min_q;
    sec_d      = sec_q;
    pre_d      = pre_q;
    mode_d     = mode_q;
    alarm_d    = 1'b0;
    ovf_d      = ovf_q;
    fifo_clr   = 1'b0;
    tick       = (state_q == ST_RUN) && (pre_q == PRE_LAST);
    lap_push   = lap & ((state_q == ST_RUN) | (state_q == ST_PAUSE));
    preset_sec = clamp_sec(load_sec);
    if (reset) begin
      state_d  = ST_IDLE;
      min_d    = '0;
      sec_d    = '0;
      pre_d    = '0;
      ovf_d    = 1'b0;
      fifo_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          pre_d = '0;
          if (!stop && start) begin
            mode_d  = mode;
            state_d = ST_RUN;
            if (mode) begin
              min_d = load_min;
              sec_d = preset_sec;
              if (load_min == '0 && preset_sec == '0) begin
                state_d = ST_DONE;
                alarm_d = 1'b1;
              end
            end
          end
        end
        ST_RUN: begin
          pre_d = tick ? '0 : pre_q + 1'b1;
          if (stop) begin
            state_d = ST_PAUSE;
          end
          if (tick) begin
            if (!mode_q) begin
              if (sec_q == SEC_MAX) begin
                sec_d = '0;
                min_d = min_q + 1'b1;
                if (min_q == MIN_MAX) begin
                  ovf_d = 1'b1;
                end
              end else begin
                sec_d = sec_q + 1'b1;
              end
            end else begin
              if (sec_q == '0) begin
                sec_d = SEC_MAX;
                min_d = min_q - 1'b1;
              end else begin
                sec_d = sec_q - 1'b1;
              end
              // reaching zero wins over a coincident stop
              if (min_d == '0 && sec_d == '0) begin
                state_d = ST_DONE;
                alarm_d = 1'b1;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (!stop && start) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          pre_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      min_q   <= '0;
      sec_q   <= '0;
      pre_q   <= '0;
      mode_q  <= 1'b0;
      alarm_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      pre_q   <= pre_d;
      mode_q  <= mode_d;
      alarm_q <= alarm_d;
      ovf_q   <= ovf_d;
    end
  end

  assign lap_in.m = min_q;
  assign lap_in.s = sec_q;

  lap_fifo #(
    .DW    ($bits(lap_t)),
    .DEPTH (LAP_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (fifo_clr),
    .push  (lap_push),
    .pop   (lap_pop),
    .din   (lap_in),
    .head  (lap_head),
    .valid (lap_valid),
    .full  (lap_full)
  );

  assign minutes = min_q;
  assign seconds = sec_q;
  assign status  = state_q;
  assign alarm   = alarm_q;
  assign ovf     = ovf_q;
  assign lap_min = lap_head.m;
  assign lap_sec = lap_head.s;

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Scoreboard bench: reference model on total seconds and a lap queue,
// expectations queued per cycle and compared by a separate monitor.
module tb_stopwatch_lap_timer;

  localparam int MW   = 8;
  localparam int TD   = 4;
  localparam int LD   = 4;
  localparam int MAXT = 256 * 60;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 0, stop = 0, reset = 0, mode = 0;
  logic [MW-1:0] load_min = '0;
  logic [5:0]    load_sec = '0;
  logic          lap = 0, lap_pop = 0;
  logic [MW-1:0] minutes;
  logic [5:0]    seconds;
  logic [1:0]    status;
  logic          alarm, ovf, lap_valid, lap_full;
  logic [MW-1:0] lap_min;
  logic [5:0]    lap_sec;

  stopwatch_lap_timer #(
    .MIN_W     (MW),
    .TICK_DIV  (TD),
    .LAP_DEPTH (LD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .reset     (reset),
    .mode      (mode),
    .load_min  (load_min),
    .load_sec  (load_sec),
    .lap       (lap),
    .lap_pop   (lap_pop),
    .minutes   (minutes),
    .seconds   (seconds),
    .status    (status),
    .alarm     (alarm),
    .ovf       (ovf),
    .lap_valid (lap_valid),
    .lap_min   (lap_min),
    .lap_sec   (lap_sec),
    .lap_full  (lap_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st, mn, sc, lm, ls;
    bit al, ov, lv, lf;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // reference model: state code, total seconds, prescaler, lap queue
  int mst = 0, mt = 0, mpre = 0, mmode = 0;
  bit movf = 0, malarm = 0;
  int laps[$];

  task automatic model_step(input bit st, sp, rs, md, lp, pp,
                            input int lm, ls);
    int  cur;
    bit  pushq, popok, done;
    cur    = mt;
    pushq  = lp && (mst == 1 || mst == 2);
    malarm = 0;
    if (rs) begin
      mst = 0; mt = 0; mpre = 0; movf = 0;
      laps.delete();
    end else begin
      popok = pp && laps.size() > 0;
      if (popok) void'(laps.pop_front());
      if (pushq && laps.size() < LD) laps.push_back(cur);
      case (mst)
        0: begin
          mpre = 0;
          if (!sp && st) begin
            mmode = md;
            mst   = 1;
            if (md) begin
              mt = lm * 60 + ((ls > 59) ? 59 : ls);
              if (mt == 0) begin mst = 3; malarm = 1; end
            end
          end
        end
        1: begin
          done = 0;
          if (mpre == TD - 1) begin
            mpre = 0;
            if (mmode == 0) begin
              mt = mt + 1;
              if (mt == MAXT) begin mt = 0; movf = 1; end
            end else begin
              mt = mt - 1;
              if (mt == 0) begin mst = 3; malarm = 1; done = 1; end
            end
          end else begin
            mpre++;
          end
          if (!done && sp) mst = 2;
        end
        2: if (!sp && st) mst = 1;
        default: mpre = 0;
      endcase
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.st = mst;
    e.mn = mt / 60;
    e.sc = mt % 60;
    e.al = malarm;
    e.ov = movf;
    e.lv = laps.size() > 0;
    e.lf = laps.size() == LD;
    e.lm = (laps.size() > 0) ? laps[0] / 60 : 0;
    e.ls = (laps.size() > 0) ? laps[0] % 60 : 0;
    return e;
  endfunction

  task automatic cyc(input bit st, sp, rs, md, lp, pp,
                     input int lm, ls);
    @(negedge clk);
    start = st; stop = sp; reset = rs; mode = md;
    lap = lp; lap_pop = pp;
    load_min = MW'(lm);
    load_sec = 6'(ls);
    model_step(st, sp, rs, md, lp, pp, lm, ls);
    sbq.push_back(snapshot());
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic sreset();
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, want);
    end
  endtask

  // monitor: one registered snapshot per clock edge
  initial begin
    exp_t e;
    bit   bad;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e   = sbq.pop_front();
        bad = (int'(status) != e.st) || (int'(minutes) != e.mn) ||
              (int'(seconds) != e.sc) || (alarm != e.al) ||
              (ovf != e.ov) || (lap_valid != e.lv) ||
              (lap_full != e.lf);
        if (e.lv && (int'(lap_min) != e.lm || int'(lap_sec) != e.ls))
          bad = 1;
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL sb t=%0t got st=%0d %0d:%0d al=%0d ov=%0d lv=%0d lf=%0d hd=%0d:%0d exp st=%0d %0d:%0d al=%0d ov=%0d lv=%0d lf=%0d hd=%0d:%0d",
                   $time, status, minutes, seconds, alarm, ovf,
                   lap_valid, lap_full, lap_min, lap_sec,
                   e.st, e.mn, e.sc, e.al, e.ov, e.lv, e.lf, e.lm, e.ls);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic async_rst();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_status", int'(status), 0);
    chk("arst_sec", int'(seconds), 0);
    chk("arst_min", int'(minutes), 0);
    chk("arst_lapv", int'(lap_valid), 0);
    mst = 0; mt = 0; mpre = 0; movf = 0; malarm = 0;
    laps.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_status", int'(status), 0);
    chk("rst_min", int'(minutes), 0);
    chk("rst_sec", int'(seconds), 0);
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_lapv", int'(lap_valid), 0);
    chk("rst_lapf", int'(lap_full), 0);
    chk("rst_lapmin", int'(lap_min), 0);
    chk("rst_lapsec", int'(lap_sec), 0);
    #1 rst = 1'b0;

    // up count
    sreset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle(244);
    sync();
    chk("up_min", int'(minutes), 1);
    chk("up_sec", int'(seconds), 1);
    chk("up_status", int'(status), 1);
    chk("up_ovf", int'(ovf), 0);

    // pause / resume
    sreset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle(5);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    idle(20);
    sync();
    chk("pause_status", int'(status), 2);
    chk("pause_sec", int'(seconds), 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    sync();
    chk("resume_sec", int'(seconds), 2);

    // countdown
    sreset();
    cyc(1, 0, 0, 1, 0, 0, 0, 2);
    idle(4);
    sync();
    chk("down_sec1", int'(seconds), 1);
    idle(4);
    sync();
    chk("down_status", int'(status), 3);
    chk("down_alarm", int'(alarm), 1);
    idle(1);
    sync();
    chk("down_alarm_off", int'(alarm), 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    sync();
    chk("done_ignore_start", int'(status), 3);

    // zero preset and clamp
    sreset();
    cyc(1, 0, 0, 1, 0, 0, 0, 0);
    sync();
    chk("zero_status", int'(status), 3);
    chk("zero_alarm", int'(alarm), 1);
    sreset();
    cyc(1, 0, 0, 1, 0, 0, 3, 63);
    sync();
    chk("clamp_sec", int'(seconds), 59);
    chk("clamp_min", int'(minutes), 3);

    // laps
    sreset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      idle(4);
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
    end
    sync();
    chk("lap_full", int'(lap_full), 1);
    chk("lap_head_sec", int'(lap_sec), 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, 0, 0);
    sync();
    chk("lap_empty", int'(lap_valid), 0);
    for (int i = 0; i < 4; i++) begin
      idle(3);
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 1, 1, 0, 0);
    sync();
    chk("lap_pushpop_full", int'(lap_full), 1);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 8) == 0, ($urandom % 16) == 0,
          ($urandom % 100) == 0, 1'($urandom % 2),
          ($urandom % 4) == 0, ($urandom % 4) == 0,
          int'($urandom % 3), int'($urandom % 64));
    end

    // asynchronous reset mid-count
    sreset();
    cyc(1, 0, 0, 0, 1, 0, 0, 0);
    idle(9);
    async_rst();
    idle(3);

    // overflow wrap
    sreset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle(MAXT * TD);
    sync();
    chk("ovf_min", int'(minutes), 0);
    chk("ovf_sec", int'(seconds), 0);
    chk("ovf_set", int'(ovf), 1);
    idle(10);
    sync();
    chk("ovf_sticky", int'(ovf), 1);
    sreset();
    sync();
    chk("ovf_clear", int'(ovf), 0);

    sync();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
